// File: rtl/even_counter_pkg.sv
// Shared types and constants for the even counter stream and its receive-side checker.
package even_counter_pkg;

    typedef enum logic [1:0] {
        HUNT,
        ACQUIRE,
        LOCKED,
        SLIP
    } check_state_t;

    localparam int DEFAULT_WIDTH = 5;
    localparam int STEP          = 2;

    // LOCKED and SLIP both count as "in lock" from the outside.
    function automatic logic is_locked_state(input check_state_t s);
        return (s == LOCKED) || (s == SLIP);
    endfunction

endpackage

// File: rtl/even_count_checker_err_sat.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
module err_sat_counter #(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    output logic [ERRW-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {ERRW{1'b1}})) begin
            count <= count + ERRW'(1);
        end
    end

endmodule

// File: rtl/even_count_checker.sv
// Receive-side checker for the even counter stream: locks on a +2 run, flags and counts errors.
// Optional wrap-to-zero pulse is built only when EVEN_CHECK_WRAP_EN is defined.
module even_count_checker
    import even_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int LOCK_LEN = 4,
    parameter int LOSS_LEN = 2,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             err,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] expected,
    output logic             wrap
);

    localparam int GW = $clog2(LOCK_LEN + 1);
    localparam int BW = $clog2(LOSS_LEN + 1);

    check_state_t     state;
    logic [GW-1:0]    good_run;
    logic [BW-1:0]    bad_run;

    logic             odd;
    logic             match;
    logic             sample_err;
    logic [WIDTH-1:0] seed_next;
    logic [WIDTH-1:0] fly_next;

    always_comb begin
        odd        = count_in[0];
        match      = (count_in == expected);
        seed_next  = count_in + WIDTH'(STEP);
        fly_next   = expected + WIDTH'(STEP);
        sample_err = valid_in && (odd || (is_locked_state(state) && !match));
    end

    // Mismatches keep the flywheel running on the prediction rather than reseeding,
    // so a single corrupted sample does not shift the lock point.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            locked   <= 1'b0;
            err      <= 1'b0;
            expected <= '0;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            err <= sample_err;
            if (valid_in) begin
                if (odd) begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    good_run <= '0;
                    bad_run  <= '0;
                end else begin
                    case (state)
                        HUNT: begin
                            expected <= seed_next;
                            good_run <= GW'(1);
                            if (LOCK_LEN == 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= ACQUIRE;
                            end
                        end
                        ACQUIRE: begin
                            if (match) begin
                                expected <= fly_next;
                                good_run <= good_run + GW'(1);
                                if ((good_run + GW'(1)) == GW'(LOCK_LEN)) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                expected <= seed_next;
                                good_run <= GW'(1);
                            end
                        end
                        LOCKED: begin
                            expected <= fly_next;
                            if (!match) begin
                                if (LOSS_LEN == 1) begin
                                    state    <= HUNT;
                                    locked   <= 1'b0;
                                    good_run <= '0;
                                    bad_run  <= '0;
                                end else begin
                                    state   <= SLIP;
                                    bad_run <= BW'(1);
                                end
                            end
                        end
                        SLIP: begin
                            expected <= fly_next;
                            if (match) begin
                                state   <= LOCKED;
                                bad_run <= '0;
                            end else if ((bad_run + BW'(1)) == BW'(LOSS_LEN)) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                bad_run <= bad_run + BW'(1);
                            end
                        end
                        default: begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    err_sat_counter #(
        .ERRW(ERRW)
    ) u_err_count (
        .clk   (clk),
        .reset (reset),
        .inc   (sample_err),
        .count (err_count)
    );

`ifdef EVEN_CHECK_WRAP_EN
    logic wrap_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= valid_in && is_locked_state(state) && (count_in == '0) && match;
        end
    end

    assign wrap = wrap_r;
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_even_count_checker.sv
// Directed, table-driven bench for even_count_checker, plus a second instance with ERRW=2 for saturation.
module tb_even_count_checker;

`ifdef EVEN_CHECK_WRAP_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    typedef struct {
        bit   rst;
        bit   valid;
        int   count;
        bit   exp_locked;
        bit   exp_err;
        int   exp_cnt;
        int   exp_next;
        bit   exp_wrap;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [4:0] count_in;

    logic       locked, err, wrap;
    logic [7:0] err_count;
    logic [4:0] expected;

    logic       sat_locked, sat_err, sat_wrap;
    logic [1:0] sat_err_count;
    logic [4:0] sat_expected;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    even_count_checker dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .count_in  (count_in),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .expected  (expected),
        .wrap      (wrap)
    );

    even_count_checker #(.ERRW(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .count_in  (count_in),
        .locked    (sat_locked),
        .err       (sat_err),
        .err_count (sat_err_count),
        .expected  (sat_expected),
        .wrap      (sat_wrap)
    );

    function automatic vec_t mk(input bit r, input bit v, input int c, input bit l,
                                input bit e, input int n, input int x, input bit w);
        vec_t t;
        t.rst = r; t.valid = v; t.count = c;
        t.exp_locked = l; t.exp_err = e; t.exp_cnt = n; t.exp_next = x; t.exp_wrap = w;
        return t;
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input int c);
        reset    = r;
        valid_in = v;
        count_in = 5'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input bit l, input bit e, input int n,
                               input int x, input bit w);
        int sat_n;
        sat_n = (n > 3) ? 3 : n;
        checkInt({tag, " locked"}, int'(locked), int'(l));
        checkInt({tag, " err"}, int'(err), int'(e));
        checkInt({tag, " err_count"}, int'(err_count), n);
        checkInt({tag, " expected"}, int'(expected), x);
        checkInt({tag, " wrap"}, int'(wrap), int'(w && WRAP_ON));
        checkInt({tag, " sat_locked"}, int'(sat_locked), int'(l));
        checkInt({tag, " sat_err"}, int'(sat_err), int'(e));
        checkInt({tag, " sat_err_count"}, int'(sat_err_count), sat_n);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        count_in = '0;
        repeat (2) @(posedge clk);
        #1;

        //                 rst valid cnt  lck err ecnt next wrap
        vecs.push_back(mk(1, 0,  0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1,  0, 0, 0, 0,  2, 0));
        vecs.push_back(mk(0, 1,  2, 0, 0, 0,  4, 0));
        vecs.push_back(mk(0, 0,  7, 0, 0, 0,  4, 0));
        vecs.push_back(mk(0, 1,  4, 0, 0, 0,  6, 0));
        vecs.push_back(mk(0, 1,  6, 1, 0, 0,  8, 0));
        vecs.push_back(mk(0, 1,  9, 0, 1, 1,  8, 0));
        vecs.push_back(mk(0, 1,  2, 0, 0, 1,  4, 0));
        vecs.push_back(mk(0, 1,  4, 0, 0, 1,  6, 0));
        vecs.push_back(mk(0, 1,  6, 0, 0, 1,  8, 0));
        vecs.push_back(mk(0, 1,  8, 1, 0, 1, 10, 0));
        vecs.push_back(mk(0, 1, 20, 1, 1, 2, 12, 0));
        vecs.push_back(mk(0, 1, 12, 1, 0, 2, 14, 0));
        vecs.push_back(mk(0, 1, 20, 1, 1, 3, 16, 0));
        vecs.push_back(mk(0, 1, 24, 0, 1, 4, 18, 0));
        vecs.push_back(mk(0, 1, 10, 0, 0, 4, 12, 0));
        vecs.push_back(mk(0, 1, 12, 0, 0, 4, 14, 0));
        vecs.push_back(mk(0, 1, 20, 0, 0, 4, 22, 0));
        vecs.push_back(mk(0, 1, 22, 0, 0, 4, 24, 0));
        vecs.push_back(mk(0, 1, 24, 0, 0, 4, 26, 0));
        vecs.push_back(mk(0, 1, 26, 1, 0, 4, 28, 0));
        vecs.push_back(mk(0, 1, 28, 1, 0, 4, 30, 0));
        vecs.push_back(mk(0, 1, 30, 1, 0, 4,  0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 4,  2, 1));
        vecs.push_back(mk(0, 1,  2, 1, 0, 4,  4, 0));
        vecs.push_back(mk(1, 1,  4, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1,  0, 0, 0, 0,  2, 0));
        vecs.push_back(mk(0, 1,  2, 0, 0, 0,  4, 0));
        vecs.push_back(mk(0, 1,  4, 0, 0, 0,  6, 0));
        vecs.push_back(mk(0, 1,  6, 1, 0, 0,  8, 0));
        vecs.push_back(mk(0, 1,  1, 0, 1, 1,  8, 0));
        vecs.push_back(mk(0, 1,  3, 0, 1, 2,  8, 0));
        vecs.push_back(mk(0, 1,  5, 0, 1, 3,  8, 0));
        vecs.push_back(mk(0, 1,  7, 0, 1, 4,  8, 0));
        vecs.push_back(mk(0, 1,  9, 0, 1, 5,  8, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 5,  8, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].count);
            checkOutput($sformatf("v%0d", i), vecs[i].exp_locked, vecs[i].exp_err,
                        vecs[i].exp_cnt, vecs[i].exp_next, vecs[i].exp_wrap);
        end

        // A slip held across a long idle gap must survive and recover on the next match.
        applyStimulus(1, 0, 0);
        checkOutput("gap reset", 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 2);
        applyStimulus(0, 1, 4);
        applyStimulus(0, 1, 6);
        checkOutput("gap lock", 1, 0, 0, 8, 0);
        applyStimulus(0, 1, 20);
        checkOutput("gap slip", 1, 1, 1, 10, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 3);
            checkOutput($sformatf("gap idle%0d", k), 1, 0, 1, 10, 0);
        end
        applyStimulus(0, 1, 10);
        checkOutput("gap recover", 1, 0, 1, 12, 0);
        applyStimulus(0, 1, 14);
        checkOutput("gap slip2", 1, 1, 2, 14, 0);
        applyStimulus(0, 1, 16);
        checkOutput("gap loss", 0, 1, 3, 16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
